// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single external memory interface.
// One transaction in flight, round-robin on ties, watchdog turns a lost completion into an error.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_ren,
  input  logic        i_p0_wen,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_valid,
  output logic        o_p0_ready,
  input  logic        i_p1_ren,
  input  logic        i_p1_wen,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_valid,
  output logic        o_p1_ready,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  input  logic        i_mem_ready,
  output logic        o_timeout
);

  localparam bit WdEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        op_wen_q, op_wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p0_valid_q, p0_valid_d;
  logic        p1_valid_q, p1_valid_d;
  logic        p0_ready_q, p0_ready_d;
  logic        p1_ready_q, p1_ready_d;
  logic        mem_ren_q, mem_ren_d;
  logic        mem_wen_q, mem_wen_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  logic        p0_req, p1_req, pick, wd_fire;
  logic [16:0] wd_next;

  assign p0_req  = i_p0_ren | i_p0_wen;
  assign p1_req  = i_p1_ren | i_p1_wen;
  // On a tie the port that was not served last wins.
  assign pick    = (p0_req && p1_req) ? ~last_grant_q : p1_req;
  assign wd_next = {1'b0, wd_cnt_q} + 17'd1;
  assign wd_fire = WdEn && (32'(wd_next) >= TIMEOUT_CYCLES);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_wen_d     = op_wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    timeout_d    = timeout_q;
    wd_cnt_d     = wd_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          grant_d  = pick;
          addr_d   = pick ? i_p1_addr : i_p0_addr;
          wdata_d  = pick ? i_p1_wdata : i_p0_wdata;
          op_wen_d = pick ? i_p1_wen : i_p0_wen;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (i_mem_ready) begin
          wd_cnt_d = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (!(&wd_cnt_q)) wd_cnt_d = wd_next[15:0];
        if (i_mem_valid) begin
          state_d = StResp;
          if (!op_wen_q) begin
            if (grant_q) p1_rdata_d = i_mem_rdata;
            else         p0_rdata_d = i_mem_rdata;
          end
        end else if (wd_fire) begin
          state_d   = StResp;
          timeout_d = 1'b1;
          if (grant_q) p1_rdata_d = '0;
          else         p0_rdata_d = '0;
        end
      end
      StResp: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so every port is driven straight from a flop.
    p0_ready_d = (state_d == StIdle);
    p1_ready_d = (state_d == StIdle);
    mem_ren_d  = (state_d == StIssue) && !op_wen_d;
    mem_wen_d  = (state_d == StIssue) && op_wen_d;
    p0_valid_d = (state_d == StResp) && !grant_d;
    p1_valid_d = (state_d == StResp) && grant_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_wen_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      p0_valid_q   <= 1'b0;
      p1_valid_q   <= 1'b0;
      p0_ready_q   <= 1'b1;
      p1_ready_q   <= 1'b1;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      timeout_q    <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_wen_q     <= op_wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_valid_q   <= p0_valid_d;
      p1_valid_q   <= p1_valid_d;
      p0_ready_q   <= p0_ready_d;
      p1_ready_q   <= p1_ready_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      timeout_q    <= timeout_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign o_p0_rdata  = p0_rdata_q;
  assign o_p0_valid  = p0_valid_q;
  assign o_p0_ready  = p0_ready_q;
  assign o_p1_rdata  = p1_rdata_q;
  assign o_p1_valid  = p1_valid_q;
  assign o_p1_ready  = p1_ready_q;
  assign o_mem_ren   = mem_ren_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory plus response/transaction scoreboards.
module tb_mem_arbiter;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_ren, p0_wen, p1_ren, p1_wen;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_valid, p0_ready, p1_valid, p1_ready;
  logic        mem_ren, mem_wen, mem_valid, mem_ready, timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.TIMEOUT_CYCLES(Timeout)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_p0_ren   (p0_ren),
    .i_p0_wen   (p0_wen),
    .i_p0_addr  (p0_addr),
    .i_p0_wdata (p0_wdata),
    .o_p0_rdata (p0_rdata),
    .o_p0_valid (p0_valid),
    .o_p0_ready (p0_ready),
    .i_p1_ren   (p1_ren),
    .i_p1_wen   (p1_wen),
    .i_p1_addr  (p1_addr),
    .i_p1_wdata (p1_wdata),
    .o_p1_rdata (p1_rdata),
    .o_p1_valid (p1_valid),
    .o_p1_ready (p1_ready),
    .o_mem_ren  (mem_ren),
    .o_mem_wen  (mem_wen),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_mem_valid(mem_valid),
    .i_mem_ready(mem_ready),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {bit port; logic [31:0] rdata;} rsp_t;
  typedef struct {bit wr; logic [31:0] addr; logic [31:0] wdata;} mtx_t;

  rsp_t        rsp_q[$];
  mtx_t        mtx_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, acc_cyc = 0, rsp_cyc = 0, req_cyc = 0;
  int          strobe_total = 0, accepts = 0, resp_total = 0;
  int          stall_left = 0, mem_delay = 1, rsp_cnt = 0;
  int          s0, a0, r0;
  logic [31:0] last_rd [2];
  logic [31:0] last_acc_addr = '0;
  logic        last_acc_wr = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon(input bit port, input logic [31:0] rd);
    rsp_t e;
    resp_total++;
    rsp_cyc = cyc;
    if (rsp_q.size() == 0) begin
      check("rsp_unexpected", 32'(rsp_q.size()), 32'd1);
      return;
    end
    e = rsp_q.pop_front();
    check("rsp_port", 32'(port), 32'(e.port));
    check("rsp_rdata", rd, e.rdata);
  endtask

  // Memory model and response monitor; everything here happens on the falling edge.
  initial begin
    mtx_t m;
    mem_ready = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = last_acc_wr ? 32'hDEAD_BEEF : mem_word(last_acc_addr);
        end
      end
      mem_ready = 1'b0;
      if (mem_ren || mem_wen) begin
        strobe_total++;
        if (mtx_q.size() == 0) check("mem_unexpected", 32'(mtx_q.size()), 32'd1);
        else check("mem_addr", mem_addr, mtx_q[0].addr);
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_ready     = 1'b1;
          accepts++;
          acc_cyc       = cyc;
          rsp_cnt       = mem_delay;
          last_acc_addr = mem_addr;
          last_acc_wr   = mem_wen;
          if (mtx_q.size() != 0) begin
            m = mtx_q.pop_front();
            check("mem_op", {30'd0, mem_wen, mem_ren}, m.wr ? 32'd2 : 32'd1);
            if (m.wr) check("mem_wdata", mem_wdata, m.wdata);
          end
        end
      end
      if (p0_valid) mon(1'b0, p0_rdata);
      if (p1_valid) mon(1'b1, p1_rdata);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      p1_ren = !wr; p1_wen = wr; p1_addr = a; p1_wdata = d;
    end else begin
      p0_ren = !wr; p0_wen = wr; p0_addr = a; p0_wdata = d;
    end
  endtask

  task automatic expect_mem(input bit wr, input logic [31:0] a, input logic [31:0] d);
    mtx_t m;
    m.wr = wr; m.addr = a; m.wdata = d;
    mtx_q.push_back(m);
  endtask

  task automatic expect_rsp(input bit port, input logic [31:0] rd);
    rsp_t r;
    r.port = port; r.rdata = rd;
    last_rd[port] = rd;
    rsp_q.push_back(r);
  endtask

  task automatic expect_tx(input bit port, input bit wr, input logic [31:0] a,
                           input logic [31:0] d);
    expect_mem(wr, a, d);
    expect_rsp(port, wr ? last_rd[port] : mem_word(a));
  endtask

  task automatic drop_all();
    p0_ren = 1'b0; p0_wen = 1'b0; p1_ren = 1'b0; p1_wen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drop_all();
    step();
    step();
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  // Requesters hold until their valid pulse unless hold is set; then all drop after n responses.
  task automatic serve(input int n, input bit hold);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      step();
      if (p0_valid) begin
        seen++;
        if (!hold) begin p0_ren = 1'b0; p0_wen = 1'b0; end
      end
      if (p1_valid) begin
        seen++;
        if (!hold) begin p1_ren = 1'b0; p1_wen = 1'b0; end
      end
    end
    if (hold) drop_all();
    check("serve_count", seen, n);
  endtask

  initial begin
    p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
    do_reset();

    check("rst_p0_ready", 32'(p0_ready), 32'd1);
    check("rst_p1_ready", 32'(p1_ready), 32'd1);
    check("rst_valids", {30'd0, p1_valid, p0_valid}, 32'd0);
    check("rst_strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Single p0 read with 1-cycle memory.
    req_cyc = cyc;
    s0      = strobe_total;
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    expect_tx(1'b0, 1'b0, 32'h10, 32'h0);
    serve(1, 1'b0);
    check("t1_strobes", strobe_total - s0, 32'd1);
    check("t1_req_to_valid", rsp_cyc - req_cyc, 32'd3);
    check("t1_mem_to_valid", rsp_cyc - acc_cyc, 32'd2);
    step();
    check("t1_valid_pulse", 32'(p0_valid), 32'd0);
    check("t1_rdata_held", p0_rdata, 32'h1234_5678);

    // Tie after reset: p0 read first, then p1 write that must not touch p1 rdata.
    do_reset();
    drive(1'b1, 1'b0, 32'h2000, 32'h0);
    expect_tx(1'b1, 1'b0, 32'h2000, 32'h0);
    serve(1, 1'b0);
    s0 = strobe_total;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'h1000, 32'hCAFE_BABE);
    expect_tx(1'b0, 1'b0, 32'h0, 32'h0);
    expect_tx(1'b1, 1'b1, 32'h1000, 32'hCAFE_BABE);
    serve(2, 1'b0);
    check("t2_strobes", strobe_total - s0, 32'd2);
    check("t2_p1_rdata_kept", p1_rdata, mem_word(32'h2000));

    // Both ports requesting continuously alternate 0,1,0,1.
    drive(1'b0, 1'b0, 32'h100, 32'h0);
    drive(1'b1, 1'b0, 32'h200, 32'h0);
    for (int k = 0; k < 2; k++) begin
      expect_tx(1'b0, 1'b0, 32'h100, 32'h0);
      expect_tx(1'b1, 1'b0, 32'h200, 32'h0);
    end
    serve(4, 1'b1);
    check("t3_rsp_drained", 32'(rsp_q.size()), 32'd0);

    // Memory stalls the strobe for three cycles.
    stall_left = 3;
    s0         = strobe_total;
    a0         = accepts;
    drive(1'b0, 1'b0, 32'h600, 32'h0);
    expect_tx(1'b0, 1'b0, 32'h600, 32'h0);
    serve(1, 1'b0);
    check("t4_strobe_cycles", strobe_total - s0, 32'd4);
    check("t4_accepts", accepts - a0, 32'd1);

    // Watchdog: memory answers far too late.
    check("t5_timeout_before", 32'(timeout), 32'd0);
    mem_delay = 20;
    drive(1'b1, 1'b0, 32'h300, 32'h0);
    expect_mem(1'b0, 32'h300, 32'h0);
    expect_rsp(1'b1, 32'h0);
    serve(1, 1'b0);
    check("t5_wait_cycles", rsp_cyc - acc_cyc, Timeout + 1);
    check("t5_timeout", 32'(timeout), 32'd1);
    mem_delay = 1;
    r0        = resp_total;
    repeat (25) step();
    check("t5_late_valid_ignored", resp_total - r0, 32'd0);
    drive(1'b0, 1'b0, 32'h500, 32'h0);
    expect_tx(1'b0, 1'b0, 32'h500, 32'h0);
    serve(1, 1'b0);
    check("t5_timeout_sticky", 32'(timeout), 32'd1);

    // Reset while waiting; the completion arrives the cycle after reset.
    mem_delay = 2;
    a0        = accepts;
    drive(1'b0, 1'b0, 32'h400, 32'h0);
    expect_mem(1'b0, 32'h400, 32'h0);
    for (int i = 0; i < 20 && accepts == a0; i++) step();
    check("t6_accepted", accepts - a0, 32'd1);
    step();
    rst = 1'b1;
    drop_all();
    step();
    rst = 1'b0;
    r0  = resp_total;
    repeat (4) step();
    mem_delay = 1;
    check("t6_no_valid", resp_total - r0, 32'd0);
    check("t6_p0_ready", 32'(p0_ready), 32'd1);
    check("t6_p1_ready", 32'(p1_ready), 32'd1);
    check("t6_timeout_cleared", 32'(timeout), 32'd0);
    check("t6_p0_rdata_cleared", p0_rdata, 32'd0);
    check("t6_no_strobe", {30'd0, mem_wen, mem_ren}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
